se_scheduler: RTL and testbench
===============================

SE_SCHEDULER -- requirements
Module: se_scheduler

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 16, word width; IN_CHANNELS, default 16, channel count; REDUCTION, default 4, squeeze ratio; IN_HEIGHT, default 8, rows; IN_WIDTH, default 8, columns; DRAIN_TIMEOUT, default 4096, max idle cycles waiting for SE outputs.
REQ-002 SHALL derive NW = IN_CHANNELS*(IN_CHANNELS/REDUCTION) weights per conv and NPIX = IN_CHANNELS*IN_HEIGHT*IN_WIDTH pixels (64 and 1024 at defaults).
REQ-003 SHALL use one clock and an asynchronous active-low reset: clk, input, 1, rising-edge clock; rst, input, 1, asynchronous active-low reset.
REQ-004 start, input, 1: single-cycle request to begin a run.
REQ-005 reload_weights, input, 1: sampled with start; forces weight reload.
REQ-006 abort, input, 1: synchronous abort of the current run.
REQ-007 w_data / w_valid, inputs, DATA_WIDTH / 1: weight source; w_ready, output, 1.
REQ-008 x_data / x_valid, inputs, DATA_WIDTH / 1: feature source; x_ready, output, 1.
REQ-009 se_in_data, output, DATA_WIDTH; se_input_valid, output, 1; se_load_kernel_conv1 and se_load_kernel_conv2, outputs, 1 each: drive the SE datapath.
REQ-010 se_out_valid, input, 1: SE output strobe.
REQ-011 busy, output, 1; done, output, 1, one-cycle pulse; timeout_err, output, 1, sticky; weights_loaded, output, 1; out_count, output, clog2(NPIX+1) bits.

Function
REQ-012 SHALL implement states IDLE, L1_PRE, L1, L1_POST, GAP, L2_PRE, L2, L2_POST, RUN, DRAIN.
REQ-013 IDLE + start: clear out_count and timeout_err; go to L1_PRE if reload_weights=1 or weights_loaded=0, else go to RUN.
REQ-014 L1_PRE lasts 1 cycle; L1 lasts until NW weight beats are accepted; L1_POST lasts 1 cycle; GAP lasts 2 cycles; L2_PRE, L2 and L2_POST mirror L1_PRE, L1 and L1_POST.
REQ-015 A beat SHALL be accepted when valid and ready are both high in the same cycle; w_ready=1 only in L1/L2 while the beat count < NW; x_ready=1 only in RUN while the pixel count < NPIX.
REQ-016 Each accepted beat SHALL appear on se_in_data with se_input_valid=1 exactly 1 cycle later; otherwise se_input_valid=0 and se_in_data holds its last value.
REQ-017 se_load_kernel_conv1 SHALL be registered high from the cycle after entry to L1_PRE through the cycle after L1_POST, and low otherwise; se_load_kernel_conv2 behaves the same for L2; the two SHALL never be high together.
REQ-018 At L2_POST exit: set weights_loaded and go to RUN.
REQ-019 RUN: after the NPIX-th pixel is accepted, go to DRAIN.
REQ-020 out_count SHALL increment on se_out_valid only in RUN/DRAIN and saturate at NPIX; strobes in other states are ignored.
REQ-021 DRAIN: when out_count==NPIX, pulse done for 1 cycle and return to IDLE.
REQ-022 DRAIN: after DRAIN_TIMEOUT consecutive cycles with no se_out_valid, set timeout_err, go to IDLE, and do not pulse done.
REQ-023 If a source stalls (valid low), hold state and counters; there is no timeout outside DRAIN.
REQ-024 busy=1 in every state except IDLE; start while busy is ignored.
REQ-025 abort in any non-IDLE state: next cycle go to IDLE, deassert all load/valid/ready outputs, and clear weights_loaded if the abort occurred in L1..L2_POST; abort has priority over any same-cycle transition.

Reset
REQ-026 rst low SHALL force IDLE and zero all counters, se_in_data, se_input_valid, se_load_kernel_conv1, se_load_kernel_conv2, w_ready, x_ready, busy, done, timeout_err, weights_loaded and out_count, including mid-run; operation resumes on the first clk edge after release.

Verification
REQ-027 Reset, then start with reload_weights=0 and continuous valid sources -> conv1 load window exactly 66 cycles with 64 valid beats, 2 idle gap cycles, conv2 load window 66 cycles with 64 beats, weights_loaded=1, then 1024 se_input_valid beats; a model returning 1024 se_out_valid strobes -> done pulses once and out_count=1024.
REQ-028 Second start after REQ-027 -> no load windows; RUN is entered the cycle after start.
REQ-029 w_valid toggling every other cycle during L1 -> still exactly 64 beats, data order preserved, load window stretches accordingly.
REQ-030 Model stops after 1000 outputs -> timeout_err=1 after 4096 idle cycles, no done, out_count=1000.
REQ-031 abort during L2 at weight 30 -> IDLE next cycle, all loads low, weights_loaded=0; next start performs a full reload.
REQ-032 rst asserted during RUN at pixel 500 -> all outputs 0 immediately; after release, start performs a full reload.

Source files
------------

// File: rtl/se_scheduler.sv
// ---------------------------------------------------------------------------
// se_scheduler : sequences SE weight loads (conv1, conv2) then feature streaming
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module se_scheduler #(
  parameter int DATA_WIDTH    = 16,
  parameter int IN_CHANNELS   = 16,
  parameter int REDUCTION     = 4,
  parameter int IN_HEIGHT     = 8,
  parameter int IN_WIDTH      = 8,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  reload_weights,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [DATA_WIDTH-1:0] x_data,
  input  logic                  x_valid,
  output logic                  x_ready,
  output logic [DATA_WIDTH-1:0] se_in_data,
  output logic                  se_input_valid,
  output logic                  se_load_kernel_conv1,
  output logic                  se_load_kernel_conv2,
  input  logic                  se_out_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  output logic                  weights_loaded,
  output logic [$clog2(IN_CHANNELS*IN_HEIGHT*IN_WIDTH+1)-1:0] out_count
);

  localparam int NW   = IN_CHANNELS * (IN_CHANNELS / REDUCTION);
  localparam int NPIX = IN_CHANNELS * IN_HEIGHT * IN_WIDTH;
  localparam int BW   = $clog2(NW + 1);
  localparam int PW   = $clog2(NPIX + 1);
  localparam int TW   = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [BW-1:0] NW_C      = BW'(NW);
  localparam logic [BW-1:0] NW_LAST   = BW'(NW - 1);
  localparam logic [PW-1:0] NPIX_C    = PW'(NPIX);
  localparam logic [PW-1:0] NPIX_LAST = PW'(NPIX - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(DRAIN_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    L1_PRE  = 4'd1,
    L1      = 4'd2,
    L1_POST = 4'd3,
    GAP     = 4'd4,
    L2_PRE  = 4'd5,
    L2      = 4'd6,
    L2_POST = 4'd7,
    RUN     = 4'd8,
    DRAIN   = 4'd9
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [BW-1:0]   beat_cnt;
  logic [PW-1:0]   pix_cnt;
  logic [TW-1:0]   idle_cnt;
  logic            gap_cnt;
  logic            w_acc;
  logic            x_acc;
  logic            in_l1;
  logic            in_l2;
  logic            finish_ok;
  logic            finish_tmo;

  assign in_l1   = (state == L1_PRE) || (state == L1) || (state == L1_POST);
  assign in_l2   = (state == L2_PRE) || (state == L2) || (state == L2_POST);
  assign busy    = (state != IDLE);
  // Ready drops during abort so no beat is consumed by a run being torn down.
  assign w_ready = ((state == L1) || (state == L2)) && (beat_cnt < NW_C) && !abort;
  assign x_ready = (state == RUN) && (pix_cnt < NPIX_C) && !abort;
  assign w_acc   = w_valid && w_ready;
  assign x_acc   = x_valid && x_ready;

  always_comb begin
    state_nx   = state;
    finish_ok  = 1'b0;
    finish_tmo = 1'b0;
    if (state != IDLE && abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nx = (reload_weights || !weights_loaded) ? L1_PRE : RUN;
        L1_PRE:  state_nx = L1;
        L1:      if (w_acc && beat_cnt == NW_LAST) state_nx = L1_POST;
        L1_POST: state_nx = GAP;
        GAP:     if (gap_cnt) state_nx = L2_PRE;
        L2_PRE:  state_nx = L2;
        L2:      if (w_acc && beat_cnt == NW_LAST) state_nx = L2_POST;
        L2_POST: state_nx = RUN;
        RUN:     if (x_acc && pix_cnt == NPIX_LAST) state_nx = DRAIN;
        DRAIN: begin
          if (out_count == NPIX_C) begin
            finish_ok = 1'b1;
            state_nx  = IDLE;
          end else if (!se_out_valid && idle_cnt == TO_LAST) begin
            finish_tmo = 1'b1;
            state_nx   = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= IDLE;
      beat_cnt             <= '0;
      pix_cnt              <= '0;
      idle_cnt             <= '0;
      gap_cnt              <= 1'b0;
      se_in_data           <= '0;
      se_input_valid       <= 1'b0;
      se_load_kernel_conv1 <= 1'b0;
      se_load_kernel_conv2 <= 1'b0;
      done                 <= 1'b0;
      timeout_err          <= 1'b0;
      weights_loaded       <= 1'b0;
      out_count            <= '0;
    end else begin
      state          <= state_nx;
      done           <= finish_ok;
      se_input_valid <= w_acc || x_acc;
      if (w_acc) begin
        se_in_data <= w_data;
      end else if (x_acc) begin
        se_in_data <= x_data;
      end
      // Load strobes trail the state by one cycle so they frame the delayed beats.
      se_load_kernel_conv1 <= in_l1 && !abort;
      se_load_kernel_conv2 <= in_l2 && !abort;

      if (state == L1_PRE || state == L2_PRE) begin
        beat_cnt <= '0;
      end else if (w_acc) begin
        beat_cnt <= beat_cnt + BW'(1);
      end

      gap_cnt <= (state == GAP) ? !gap_cnt : 1'b0;

      if (state == IDLE && start) begin
        pix_cnt <= '0;
      end else if (x_acc) begin
        pix_cnt <= pix_cnt + PW'(1);
      end

      if (state != DRAIN || se_out_valid) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + TW'(1);
      end

      if (state == IDLE && start) begin
        out_count <= '0;
      end else if ((state == RUN || state == DRAIN) && se_out_valid && out_count != NPIX_C) begin
        out_count <= out_count + PW'(1);
      end

      if (state == IDLE && start) begin
        timeout_err <= 1'b0;
      end else if (finish_tmo) begin
        timeout_err <= 1'b1;
      end

      // A load sequence cut short leaves the SE kernels in an unknown mix.
      if (abort && (in_l1 || in_l2 || state == GAP)) begin
        weights_loaded <= 1'b0;
      end else if (state == L2_POST) begin
        weights_loaded <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_se_scheduler.sv
// ---------------------------------------------------------------------------
// tb_se_scheduler : directed scenarios with a phase-level reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_se_scheduler;

  localparam int DW   = 16;
  localparam int NW   = 64;
  localparam int NPIX = 1024;
  localparam int TO   = 4096;

  localparam int P_IDLE = 0, P_PRE1 = 1, P_LD1 = 2, P_POST1 = 3, P_GAP = 4;
  localparam int P_PRE2 = 5, P_LD2 = 6, P_POST2 = 7, P_RUN = 8, P_DRAIN = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, reload_weights, abort;
  logic [DW-1:0] w_data, x_data;
  logic          w_valid, x_valid, w_ready, x_ready;
  logic [DW-1:0] se_in_data;
  logic          se_input_valid, se_load_kernel_conv1, se_load_kernel_conv2;
  logic          se_out_valid;
  logic          busy, done, timeout_err, weights_loaded;
  logic [10:0]   out_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  se_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .reload_weights(reload_weights), .abort(abort),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .se_in_data(se_in_data), .se_input_valid(se_input_valid),
    .se_load_kernel_conv1(se_load_kernel_conv1), .se_load_kernel_conv2(se_load_kernel_conv2),
    .se_out_valid(se_out_valid), .busy(busy), .done(done), .timeout_err(timeout_err),
    .weights_loaded(weights_loaded), .out_count(out_count)
  );

  function automatic void check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endfunction

  // ---------------- sources: valid/data advance on handshake ----------------
  logic w_on = 1'b0, x_on = 1'b0, w_toggle = 1'b0;
  logic w_fire = 1'b0, x_fire = 1'b0;
  int   w_idx = 0, x_idx = 0, w_tick = 0;

  always @(negedge clk) begin
    w_fire = w_valid && w_ready;
    x_fire = x_valid && x_ready;
  end

  always @(posedge clk) begin
    #1;
    if (w_fire) w_idx++;
    if (x_fire) x_idx++;
    w_tick++;
    w_valid = w_on && (!w_toggle || w_tick[0]);
    x_valid = x_on;
    w_data  = 16'(32'h1000 + 3 * w_idx);
    x_data  = 16'(32'h4000 + 7 * x_idx);
  end

  // ---------------- SE datapath stand-in: one strobe per pixel, 2 cycles late -
  int se_limit = 100000;
  int se_q[$];
  int se_cyc = 0;
  int se_issued = 0;

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      se_q.delete();
      se_issued    = 0;
      se_out_valid = 1'b0;
    end else begin
      se_cyc++;
      if (start && !busy) se_issued = 0;
      if (se_input_valid && !se_load_kernel_conv1 && !se_load_kernel_conv2 && se_issued < se_limit) begin
        se_q.push_back(se_cyc + 2);
        se_issued++;
      end
      se_out_valid = 1'b0;
      if (se_q.size() > 0 && se_q[0] <= se_cyc) begin
        void'(se_q.pop_front());
        se_out_valid = 1'b1;
      end
    end
  end

  // ---------------- reference model: phase timeline ----------------
  int          m_ph = 0, m_left = 0, m_beats = 0, m_pix = 0, m_outs = 0, m_idle = 0;
  bit          m_wl = 0, m_terr = 0, m_dv = 0, m_l1 = 0, m_l2 = 0, m_done = 0;
  logic [DW-1:0] m_din = '0;

  always @(posedge clk or negedge rst) begin : ref_model
    bit aw, ax;
    int ph0, outs0;
    if (!rst) begin
      m_ph = P_IDLE; m_left = 0; m_beats = 0; m_pix = 0; m_outs = 0; m_idle = 0;
      m_wl = 0; m_terr = 0; m_dv = 0; m_l1 = 0; m_l2 = 0; m_done = 0; m_din = '0;
    end else begin
      ph0   = m_ph;
      outs0 = m_outs;
      aw = (ph0 == P_LD1 || ph0 == P_LD2) && m_beats < NW && !abort && w_valid;
      ax = (ph0 == P_RUN) && m_pix < NPIX && !abort && x_valid;
      m_dv = aw || ax;
      if (aw) m_din = w_data;
      else if (ax) m_din = x_data;
      m_l1 = !abort && ph0 >= P_PRE1 && ph0 <= P_POST1;
      m_l2 = !abort && ph0 >= P_PRE2 && ph0 <= P_POST2;
      m_done = 0;
      if (aw) m_beats++;
      if (ax) m_pix++;
      if ((ph0 == P_RUN || ph0 == P_DRAIN) && se_out_valid && m_outs < NPIX) m_outs++;
      if (ph0 == P_IDLE) begin
        if (start) begin
          m_outs = 0; m_terr = 0; m_pix = 0; m_beats = 0; m_left = 1;
          m_ph = (reload_weights || !m_wl) ? P_PRE1 : P_RUN;
        end
      end else if (abort) begin
        if (ph0 <= P_POST2) m_wl = 0;
        m_ph = P_IDLE;
      end else if (ph0 == P_LD1 || ph0 == P_LD2) begin
        if (m_beats == NW) begin m_ph = ph0 + 1; m_left = 1; end
      end else if (ph0 == P_RUN) begin
        if (m_pix == NPIX) begin m_ph = P_DRAIN; m_idle = 0; end
      end else if (ph0 == P_DRAIN) begin
        if (outs0 == NPIX) begin m_done = 1; m_ph = P_IDLE; end
        else if (se_out_valid) m_idle = 0;
        else if (m_idle == TO - 1) begin m_terr = 1; m_ph = P_IDLE; end
        else m_idle++;
      end else begin
        m_left--;
        if (m_left == 0) begin
          if (ph0 == P_POST2) begin
            m_wl = 1; m_ph = P_RUN;
          end else begin
            m_ph   = ph0 + 1;
            m_left = (m_ph == P_GAP) ? 2 : 1;
            if (m_ph == P_PRE2) m_beats = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [8:0] got_f, exp_f;
    bit exp_wr, exp_xr;
    exp_wr = (m_ph == P_LD1 || m_ph == P_LD2) && m_beats < NW && !abort;
    exp_xr = (m_ph == P_RUN) && m_pix < NPIX && !abort;
    got_f = {busy, w_ready, x_ready, se_input_valid, se_load_kernel_conv1,
             se_load_kernel_conv2, done, timeout_err, weights_loaded};
    exp_f = {m_ph != P_IDLE, exp_wr, exp_xr, m_dv, m_l1, m_l2, m_done, m_terr, m_wl};
    checks++;
    if (got_f !== exp_f || int'(out_count) != m_outs || se_in_data !== m_din) begin
      errors++;
      $display("FAIL cycle_model t=%0t flags got %b expected %b out_count got %0d expected %0d data got %h expected %h",
               $time, got_f, exp_f, out_count, m_outs, se_in_data, m_din);
    end
  end

  // ---------------- window observer, cleared at each accepted start ----------
  int l1_len, l1_beats, l2_len, l2_beats, gap_len, pix_beats, done_cnt;
  logic [DW-1:0] w1q[$];

  always @(negedge clk) begin
    if (rst && start && !busy) begin
      l1_len = 0; l1_beats = 0; l2_len = 0; l2_beats = 0;
      gap_len = 0; pix_beats = 0; done_cnt = 0;
      w1q.delete();
    end else begin
      if (se_load_kernel_conv1) begin
        l1_len++;
        if (se_input_valid) begin l1_beats++; w1q.push_back(se_in_data); end
      end
      if (se_load_kernel_conv2) begin
        l2_len++;
        if (se_input_valid) l2_beats++;
      end
      if (!se_load_kernel_conv1 && !se_load_kernel_conv2 && l1_len > 0 && l2_len == 0) gap_len++;
      if (se_input_valid && !se_load_kernel_conv1 && !se_load_kernel_conv2) pix_beats++;
      if (done) done_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start(input logic rl);
    @(posedge clk); #1;
    start = 1'b1; reload_weights = rl;
    @(posedge clk); #1;
    start = 1'b0; reload_weights = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < budget) begin @(negedge clk); n++; end
    check({name, "_reached_idle"}, busy, 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic bit w1_in_order();
    if (w1q.size() != NW) return 1'b0;
    for (int k = 0; k < w1q.size(); k++)
      if (w1q[k] != 16'(w1q[0] + 3 * k)) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; reload_weights = 1'b0; abort = 1'b0;
    w_valid = 1'b0; x_valid = 1'b0; w_data = '0; x_data = '0;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_out_count", out_count, 0);
    check("reset_weights_loaded", weights_loaded, 0);
    check("reset_loads", {se_load_kernel_conv1, se_load_kernel_conv2}, 0);
    check("reset_in_valid", se_input_valid, 0);
    rst = 1'b1;
    w_on = 1'b1; x_on = 1'b1;
    repeat (2) @(posedge clk);

    // first run: weights never loaded, so full load sequence despite reload=0
    pulse_start(1'b0);
    wait_idle(3000, "t1");
    check("t1_l1_window", l1_len, 66);
    check("t1_l1_beats", l1_beats, 64);
    check("t1_gap", gap_len, 2);
    check("t1_l2_window", l2_len, 66);
    check("t1_l2_beats", l2_beats, 64);
    check("t1_pixels", pix_beats, 1024);
    check("t1_done_pulses", done_cnt, 1);
    check("t1_out_count", out_count, 1024);
    check("t1_weights_loaded", weights_loaded, 1);
    check("t1_w1_order", w1_in_order(), 1);

    // second run: straight to streaming
    pulse_start(1'b0);
    check("t2_x_ready_next_cycle", x_ready, 1);
    check("t2_no_load_now", se_load_kernel_conv1, 0);
    wait_idle(3000, "t2");
    check("t2_l1_window", l1_len, 0);
    check("t2_l2_window", l2_len, 0);
    check("t2_done_pulses", done_cnt, 1);
    check("t2_out_count", out_count, 1024);

    // forced reload with weight source valid every other cycle
    w_toggle = 1'b1;
    pulse_start(1'b1);
    wait_idle(4000, "t3");
    w_toggle = 1'b0;
    check("t3_l1_beats", l1_beats, 64);
    check("t3_l1_window_stretched", (l1_len >= 129 && l1_len <= 130), 1);
    check("t3_w1_order", w1_in_order(), 1);
    check("t3_done_pulses", done_cnt, 1);

    // SE stops responding after 1000 outputs
    se_limit = 1000;
    pulse_start(1'b0);
    wait_idle(7000, "t4");
    se_limit = 100000;
    check("t4_timeout_err", timeout_err, 1);
    check("t4_done_pulses", done_cnt, 0);
    check("t4_out_count", out_count, 1000);

    // abort during conv2 load
    pulse_start(1'b1);
    n = 0;
    while (l2_beats < 30 && n < 1000) begin @(negedge clk); n++; end
    check("t5_reached_w30", (l2_beats >= 30), 1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("t5_idle_after_abort", busy, 0);
    check("t5_loads_low", {se_load_kernel_conv1, se_load_kernel_conv2}, 0);
    check("t5_weights_cleared", weights_loaded, 0);
    check("t5_w_ready_low", w_ready, 0);
    check("t5_timeout_cleared", timeout_err, 0);
    pulse_start(1'b0);
    wait_idle(3000, "t5b");
    check("t5_reload_l1", l1_len, 66);
    check("t5_reload_l2", l2_len, 66);
    check("t5_done_pulses", done_cnt, 1);

    // reset in the middle of streaming
    pulse_start(1'b0);
    n = 0;
    while (pix_beats < 500 && n < 2000) begin @(negedge clk); n++; end
    check("t6_reached_px500", (pix_beats >= 500), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_ready", {w_ready, x_ready}, 0);
    check("t6_in_valid", se_input_valid, 0);
    check("t6_in_data", se_in_data, 0);
    check("t6_out_count", out_count, 0);
    check("t6_weights_loaded", weights_loaded, 0);
    check("t6_flags", {se_load_kernel_conv1, se_load_kernel_conv2, done, timeout_err}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    pulse_start(1'b0);
    wait_idle(3000, "t6b");
    check("t6_reload_l1", l1_len, 66);
    check("t6_reload_l2", l2_len, 66);
    check("t6_out_count_final", out_count, 1024);
    check("t6_done_pulses", done_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
